// File: rtl/inst_dispatch.sv
// inst_dispatch: buffers instructions from the host in a DEPTH-entry FIFO.
// Issues each instruction to the core as a one-cycle inst/inst_valid pulse.
// Waits for core_done before popping the next entry.
// NOP entries (opcode 3'b000) are popped and dropped without being issued.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   host_inst, host_valid  enqueue request; host_ready = !full
//   inst, inst_valid       issued instruction (held) and its one-cycle pulse
//   core_done              completion pulse from the core
//   busy                   high while waiting for core_done
//   count                  FIFO occupancy
//   err_timeout            watchdog pulse (INST_DISPATCH_TIMEOUT_EN only)
//
// Build option: define INST_DISPATCH_TIMEOUT_EN to add a watchdog that
// abandons a WAIT after TIMEOUT cycles without core_done.
module inst_dispatch #(
  parameter int INST_WIDTH = 27,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [INST_WIDTH-1:0]   host_inst,
  input  logic                    host_valid,
  output logic                    host_ready,
  output logic [INST_WIDTH-1:0]   inst,
  output logic                    inst_valid,
  input  logic                    core_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state;
  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  timeout_hit;
  logic [INST_WIDTH-1:0] head;

  assign host_ready = (count != CW'(DEPTH));
  assign push       = host_valid && host_ready;
  assign head       = mem[rptr];
  // The pop decision uses the registered count, so a push into an empty
  // FIFO becomes visible to IDLE one cycle later.
  assign pop        = (state == IDLE) && (count != '0);
  assign issue      = pop && (head[INST_WIDTH-1 -: 3] != 3'b000);
  assign busy       = (state == WAIT);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= host_inst;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      inst       <= '0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            inst       <= head;
            inst_valid <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (core_done || timeout_hit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INST_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;

  // core_done on the limit cycle wins over the timeout.
  assign timeout_hit = (state == WAIT) && !core_done && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (issue)               tcnt <= '0;
      else if (state == WAIT)  tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
